// File: rtl/tile_cfg_frame_loader.sv
// ---------------------------------------------------------------------------
// tile_cfg_frame_loader
//
// Per-tile configuration loader. Addressed config words arrive from the
// upstream tile over a valid/ready stream. Words addressed to this tile
// (or broadcast) are written segment by segment into a bitline shadow
// register. A word flagged 'last' commits the row by firing a wordline pulse
// of WL_PULSE cycles, followed by one hold cycle with all wordlines low.
// Words for other tiles, and broadcast words, are forwarded downstream
// through a single registered slot.
//
// Ports
//   prog_clk       in   programming clock
//   pReset         in   synchronous active-high reset
//   cfg_in_*       in   upstream word (valid/data/dest/seg/wl/last), ready out
//   cfg_out_*      out  forwarded word (valid/data/dest/seg/wl/last), ready in
//   bl             out  bitline drive, bl[s*WORD_W+i] = segment s, data bit i
//   wl             out  wordline drive, at most one bit high
//   cfg_err        out  sticky error (bad segment or bad wordline index)
//   prog_count     out  rows programmed, saturating
// ---------------------------------------------------------------------------
module tile_cfg_frame_loader #(
    parameter int NUM_BL   = 80,
    parameter int NUM_WL   = 80,
    parameter int WORD_W   = 40,
    parameter int ID_W     = 8,
    parameter int TILE_ID  = 0,
    parameter int WL_PULSE = 2,
    localparam int NUM_SEG = NUM_BL / WORD_W,
    localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
    localparam int WLI_W   = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_in_valid,
    output logic              cfg_in_ready,
    input  logic [WORD_W-1:0] cfg_in_data,
    input  logic [ID_W-1:0]   cfg_in_dest,
    input  logic [SEG_W-1:0]  cfg_in_seg,
    input  logic [WLI_W-1:0]  cfg_in_wl,
    input  logic              cfg_in_last,
    output logic              cfg_out_valid,
    input  logic              cfg_out_ready,
    output logic [WORD_W-1:0] cfg_out_data,
    output logic [ID_W-1:0]   cfg_out_dest,
    output logic [SEG_W-1:0]  cfg_out_seg,
    output logic [WLI_W-1:0]  cfg_out_wl,
    output logic              cfg_out_last,
    output logic [0:NUM_BL-1] bl,
    output logic [0:NUM_WL-1] wl,
    output logic              cfg_err,
    output logic [15:0]       prog_count
);

    localparam int CNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
    localparam logic [31:0] NUM_SEG_U = NUM_SEG;
    localparam logic [31:0] NUM_WL_U  = NUM_WL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WLI_W-1:0]   wl_idx_r;
    logic [0:NUM_BL-1]  bl_r;
    logic [0:NUM_WL-1]  wl_r;
    logic [0:NUM_WL-1]  wl_nxt_s;
    logic               cfg_err_r;
    logic [15:0]        prog_count_r;

    logic               out_valid_r;
    logic [WORD_W-1:0]  out_data_r;
    logic [ID_W-1:0]    out_dest_r;
    logic [SEG_W-1:0]   out_seg_r;
    logic [WLI_W-1:0]   out_wl_r;
    logic               out_last_r;

    logic               is_local_s;
    logic               is_bcast_s;
    logic               slot_free_s;
    logic               ready_s;
    logic               in_fire_s;
    logic               fwd_load_s;
    logic               consume_s;
    logic               seg_ok_s;
    logic               wl_ok_s;
    logic               seg_wr_s;
    logic               start_s;
    logic               err_set_s;
    logic [WLI_W-1:0]   pulse_idx_s;

    assign is_local_s  = (cfg_in_dest == ID_W'(TILE_ID));
    assign is_bcast_s  = &cfg_in_dest;
    assign slot_free_s = !out_valid_r || cfg_out_ready;
    assign seg_ok_s    = 32'(cfg_in_seg) < NUM_SEG_U;
    assign wl_ok_s     = 32'(cfg_in_wl) < NUM_WL_U;

    // Input acceptance: local words need the FSM idle, broadcast words also
    // need the out slot, everything else only needs the out slot.
    always_comb begin
        ready_s = 1'b0;
        if (is_bcast_s) begin
            ready_s = (state_r == ST_IDLE) && slot_free_s;
        end else if (is_local_s) begin
            ready_s = (state_r == ST_IDLE);
        end else begin
            ready_s = slot_free_s;
        end
    end

    assign cfg_in_ready = ready_s;
    assign in_fire_s    = cfg_in_valid && ready_s;
    assign fwd_load_s   = in_fire_s && !is_local_s;
    assign consume_s    = in_fire_s && (is_local_s || is_bcast_s);
    assign seg_wr_s     = consume_s && seg_ok_s;
    // A dropped (bad-segment) word never commits a row, even if flagged last.
    assign start_s      = consume_s && seg_ok_s && cfg_in_last && wl_ok_s;
    assign err_set_s    = consume_s && (!seg_ok_s || (cfg_in_last && !wl_ok_s));

    // FSM state register
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_PULSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_PULSE;
                end
            end
            ST_HOLD: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next wordline vector, registered below so wl is
    // high exactly while the FSM sits in PULSE.
    always_comb begin
        wl_nxt_s    = '0;
        pulse_idx_s = wl_idx_r;
        if (start_s) begin
            pulse_idx_s = cfg_in_wl;
        end else begin
            pulse_idx_s = wl_idx_r;
        end
        for (int j = 0; j < NUM_WL; j++) begin
            wl_nxt_s[j] = (state_nxt_s == ST_PULSE) && (pulse_idx_s == WLI_W'(j));
        end
    end

    // Pulse counter and latched wordline index
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cnt_r    <= '0;
            wl_idx_r <= '0;
        end else if (start_s) begin
            cnt_r    <= CNT_W'(WL_PULSE - 1);
            wl_idx_r <= cfg_in_wl;
        end else if ((state_r == ST_PULSE) && (cnt_r != '0)) begin
            cnt_r    <= cnt_r - CNT_W'(1);
        end
    end

    // Wordline, error flag and programmed-row counter registers
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            wl_r         <= '0;
            cfg_err_r    <= 1'b0;
            prog_count_r <= 16'd0;
        end else begin
            wl_r <= wl_nxt_s;
            if (err_set_s) begin
                cfg_err_r <= 1'b1;
            end
            if (state_r == ST_HOLD) begin
                prog_count_r <= sat_inc16(prog_count_r);
            end
        end
    end

    // Bitline shadow register; bit i of a segment lands on bl[s*WORD_W+i]
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bl_r <= '0;
        end else if (seg_wr_s) begin
            for (int s = 0; s < NUM_SEG; s++) begin
                for (int i = 0; i < WORD_W; i++) begin
                    if (cfg_in_seg == SEG_W'(s)) begin
                        bl_r[s*WORD_W+i] <= cfg_in_data[i];
                    end
                end
            end
        end
    end

    // Downstream slot: loads on acceptance, holds while stalled
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_dest_r  <= '0;
            out_seg_r   <= '0;
            out_wl_r    <= '0;
            out_last_r  <= 1'b0;
        end else if (fwd_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= cfg_in_data;
            out_dest_r  <= cfg_in_dest;
            out_seg_r   <= cfg_in_seg;
            out_wl_r    <= cfg_in_wl;
            out_last_r  <= cfg_in_last;
        end else if (cfg_out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bl            = bl_r;
    assign wl            = wl_r;
    assign cfg_err       = cfg_err_r;
    assign prog_count    = prog_count_r;
    assign cfg_out_valid = out_valid_r;
    assign cfg_out_data  = out_data_r;
    assign cfg_out_dest  = out_dest_r;
    assign cfg_out_seg   = out_seg_r;
    assign cfg_out_wl    = out_wl_r;
    assign cfg_out_last  = out_last_r;

endmodule

// File: tb/tb_tile_cfg_frame_loader.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for tile_cfg_frame_loader.
// Uses TILE_ID=3 and three 40-bit segments (NUM_BL=120) so that an
// out-of-range segment index (3) is representable on the 2-bit seg field.
// ---------------------------------------------------------------------------
module tb_tile_cfg_frame_loader;

    localparam int NUM_BL = 120;
    localparam int NUM_WL = 80;
    localparam int WORD_W = 40;
    localparam int ID_W   = 8;
    localparam int SEG_W  = 2;
    localparam int WLI_W  = 7;

    logic              prog_clk;
    logic              pReset;
    logic              cfg_in_valid;
    logic              cfg_in_ready;
    logic [WORD_W-1:0] cfg_in_data;
    logic [ID_W-1:0]   cfg_in_dest;
    logic [SEG_W-1:0]  cfg_in_seg;
    logic [WLI_W-1:0]  cfg_in_wl;
    logic              cfg_in_last;
    logic              cfg_out_valid;
    logic              cfg_out_ready;
    logic [WORD_W-1:0] cfg_out_data;
    logic [ID_W-1:0]   cfg_out_dest;
    logic [SEG_W-1:0]  cfg_out_seg;
    logic [WLI_W-1:0]  cfg_out_wl;
    logic              cfg_out_last;
    logic [0:NUM_BL-1] bl;
    logic [0:NUM_WL-1] wl;
    logic              cfg_err;
    logic [15:0]       prog_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:NUM_BL-1] exp_bl;

    tile_cfg_frame_loader #(
        .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .WORD_W(WORD_W), .ID_W(ID_W),
        .TILE_ID(3), .WL_PULSE(2)
    ) dut (
        .prog_clk(prog_clk), .pReset(pReset),
        .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
        .cfg_in_data(cfg_in_data), .cfg_in_dest(cfg_in_dest),
        .cfg_in_seg(cfg_in_seg), .cfg_in_wl(cfg_in_wl), .cfg_in_last(cfg_in_last),
        .cfg_out_valid(cfg_out_valid), .cfg_out_ready(cfg_out_ready),
        .cfg_out_data(cfg_out_data), .cfg_out_dest(cfg_out_dest),
        .cfg_out_seg(cfg_out_seg), .cfg_out_wl(cfg_out_wl), .cfg_out_last(cfg_out_last),
        .bl(bl), .wl(wl), .cfg_err(cfg_err), .prog_count(prog_count)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:NUM_WL-1] oh(input int k);
        logic [0:NUM_WL-1] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic set_exp_seg(input int s, input logic [WORD_W-1:0] d);
        for (int i = 0; i < WORD_W; i++) exp_bl[s*WORD_W+i] = d[i];
    endtask

    task automatic drive(input logic v, input logic [ID_W-1:0] dest, input logic [SEG_W-1:0] seg,
                         input logic [WLI_W-1:0] wli, input logic last, input logic [WORD_W-1:0] d);
        cfg_in_valid = v;
        cfg_in_dest  = dest;
        cfg_in_seg   = seg;
        cfg_in_wl    = wli;
        cfg_in_last  = last;
        cfg_in_data  = d;
        #1;
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    initial begin
        exp_bl        = '0;
        pReset        = 1'b1;
        cfg_out_ready = 1'b1;
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);

        // 1. reset
        tick(); tick();
        pReset = 1'b0;
        chk("rst_bl", 128'(bl), 128'(0));
        chk("rst_wl", 128'(wl), 128'(0));
        chk("rst_out_valid", 128'(cfg_out_valid), 128'(0));
        chk("rst_err", 128'(cfg_err), 128'(0));
        chk("rst_count", 128'(prog_count), 128'(0));
        drive(1'b1, 8'd7, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("rst_ready_fwd", 128'(cfg_in_ready), 128'(1));
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);

        // 2. local row: seg0 then seg1+last on wl 5
        drive(1'b1, 8'd3, 2'd0, 7'd0, 1'b0, 40'hA5A5A5A5A5);
        chk("row_ready_seg0", 128'(cfg_in_ready), 128'(1));
        tick();
        drive(1'b1, 8'd3, 2'd1, 7'd5, 1'b1, 40'h0F0F0F0F0F);
        set_exp_seg(0, 40'hA5A5A5A5A5);
        chk("row_bl_seg0", 128'(bl), 128'(exp_bl));
        tick();
        set_exp_seg(1, 40'h0F0F0F0F0F);
        drive(1'b1, 8'd3, 2'd2, 7'd1, 1'b0, 40'hDEADDEADDE);
        chk("row_pulse1_wl", 128'(wl), 128'(oh(5)));
        chk("row_pulse1_ready", 128'(cfg_in_ready), 128'(0));
        chk("row_bl_full", 128'(bl), 128'(exp_bl));
        tick();
        chk("row_pulse2_wl", 128'(wl), 128'(oh(5)));
        chk("row_pulse2_ready", 128'(cfg_in_ready), 128'(0));
        tick();
        chk("row_hold_wl", 128'(wl), 128'(0));
        chk("row_hold_ready", 128'(cfg_in_ready), 128'(0));
        chk("row_hold_bl", 128'(bl), 128'(exp_bl));
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        tick();
        chk("row_count", 128'(prog_count), 128'(1));
        chk("row_idle_wl", 128'(wl), 128'(0));
        chk("row_no_fwd", 128'(cfg_out_valid), 128'(0));
        chk("row_bl_kept", 128'(bl), 128'(exp_bl));

        // 3. forward word, then stalled slot
        drive(1'b1, 8'd7, 2'd2, 7'd9, 1'b1, 40'h1234567890);
        chk("fwd_ready", 128'(cfg_in_ready), 128'(1));
        tick();
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("fwd_valid", 128'(cfg_out_valid), 128'(1));
        chk("fwd_word", 128'({cfg_out_data, cfg_out_dest, cfg_out_seg, cfg_out_wl, cfg_out_last}),
            128'({40'h1234567890, 8'd7, 2'd2, 7'd9, 1'b1}));
        chk("fwd_bl", 128'(bl), 128'(exp_bl));
        chk("fwd_wl", 128'(wl), 128'(0));
        tick();
        chk("fwd_drained", 128'(cfg_out_valid), 128'(0));
        cfg_out_ready = 1'b0;
        drive(1'b1, 8'd9, 2'd0, 7'd0, 1'b0, 40'h0000000111);
        tick();
        drive(1'b1, 8'd10, 2'd0, 7'd0, 1'b0, 40'h0000000222);
        chk("stall_ready", 128'(cfg_in_ready), 128'(0));
        tick();
        chk("stall_hold_data", 128'(cfg_out_data), 128'(40'h0000000111));
        chk("stall_hold_valid", 128'(cfg_out_valid), 128'(1));
        cfg_out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 128'(cfg_in_ready), 128'(1));
        tick();
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("stall_second_data", 128'({cfg_out_data, cfg_out_dest}), 128'({40'h0000000222, 8'd10}));
        tick();
        chk("stall_drained", 128'(cfg_out_valid), 128'(0));

        // 4. broadcast blocked by a full slot, then forwarded and programmed
        cfg_out_ready = 1'b0;
        drive(1'b1, 8'd20, 2'd0, 7'd0, 1'b0, 40'h00000000CC);
        tick();
        drive(1'b1, 8'hFF, 2'd0, 7'd0, 1'b1, 40'hCAFEBABE00);
        chk("bc_stall_ready", 128'(cfg_in_ready), 128'(0));
        tick();
        chk("bc_stall_wl", 128'(wl), 128'(0));
        chk("bc_stall_slot", 128'(cfg_out_data), 128'(40'h00000000CC));
        cfg_out_ready = 1'b1;
        #1;
        chk("bc_ready", 128'(cfg_in_ready), 128'(1));
        tick();
        set_exp_seg(0, 40'hCAFEBABE00);
        chk("bc_fwd_word", 128'({cfg_out_valid, cfg_out_data, cfg_out_dest, cfg_out_last}),
            128'({1'b1, 40'hCAFEBABE00, 8'hFF, 1'b1}));
        chk("bc_wl", 128'(wl), 128'(oh(0)));
        chk("bc_bl", 128'(bl), 128'(exp_bl));
        drive(1'b1, 8'd5, 2'd1, 7'd3, 1'b0, 40'h5555555555);
        chk("pulse_fwd_ready", 128'(cfg_in_ready), 128'(1));
        tick();
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("pulse_fwd_data", 128'({cfg_out_data, cfg_out_dest}), 128'({40'h5555555555, 8'd5}));
        chk("bc_wl2", 128'(wl), 128'(oh(0)));
        tick();
        chk("bc_hold_wl", 128'(wl), 128'(0));
        tick();
        chk("bc_count", 128'(prog_count), 128'(2));

        // 5. error cases
        drive(1'b1, 8'd3, 2'd3, 7'd0, 1'b0, 40'hFFFFFFFFFF);
        chk("err_seg_ready", 128'(cfg_in_ready), 128'(1));
        tick();
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("err_seg_flag", 128'(cfg_err), 128'(1));
        chk("err_seg_bl", 128'(bl), 128'(exp_bl));
        drive(1'b1, 8'd3, 2'd2, 7'd80, 1'b1, 40'h00000000FF);
        tick();
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        set_exp_seg(2, 40'h00000000FF);
        chk("err_wl_bl", 128'(bl), 128'(exp_bl));
        for (int k = 0; k < 3; k++) begin
            chk("err_wl_quiet", 128'(wl), 128'(0));
            tick();
        end
        chk("err_wl_count", 128'(prog_count), 128'(2));
        chk("err_sticky", 128'(cfg_err), 128'(1));

        // 6. reset during the first PULSE cycle
        drive(1'b1, 8'd3, 2'd0, 7'd7, 1'b1, 40'h0000012345);
        tick();
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("rp_wl_pulse", 128'(wl), 128'(oh(7)));
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        chk("rp_wl", 128'(wl), 128'(0));
        chk("rp_count", 128'(prog_count), 128'(0));
        chk("rp_err", 128'(cfg_err), 128'(0));
        chk("rp_bl", 128'(bl), 128'(0));
        drive(1'b1, 8'd3, 2'd0, 7'd0, 1'b0, 40'h0);
        chk("rp_idle_ready", 128'(cfg_in_ready), 128'(1));
        drive(1'b0, 8'd0, 2'd0, 7'd0, 1'b0, 40'h0);
        tick();
        chk("rp_wl_after", 128'(wl), 128'(0));
        chk("rp_count_after", 128'(prog_count), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
